// File: rtl/mem_macro_arbiter.sv
// -----------------------------------------------------------------------------
// mem_macro_arbiter
//
// Arbitrates two requesters (port 0 = instruction fetch, port 1 = load/store)
// onto one single-port memory macro. It grants at most one access per cycle,
// using round-robin or fixed priority. A port can extend its grant with a
// bounded lock burst. Every access returns a completion pulse and data to its
// port two cycles after the grant.
//
// Ports
//   clka, rsta_n            clock (rising edge), async active-low reset
//   reqN/weN/lockN          request valid, write select, keep-grant request
//   addrN/wdataN            word address and write data
//   gntN                    combinational grant (request accepted this cycle)
//   rvalidN/rdataN          registered completion pulse and held data
//   mem_ena/wea/addra/dina  macro controls, muxed from the granted port
//   mem_douta               macro output, valid the cycle after mem_ena
// -----------------------------------------------------------------------------
module mem_macro_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  // The lock counter never exceeds MAX_LOCK-1.
  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK - 1);

  port_e            last_gnt_q;
  logic             granted_q;     // a grant was issued in the previous cycle
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             s1_valid_q;
  port_e            s1_port_q;
  logic             rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic lock0_act, lock1_act;
  logic g0, g1;

  // A port keeps priority only if it won the previous cycle and is still
  // locking within its burst budget. At most one of these can be active
  // because last_gnt_q names a single port.
  assign lock0_act = granted_q && (last_gnt_q == PORT0) && req0 && lock0 &&
                     (lock_cnt_q < LOCK_LIMIT);
  assign lock1_act = granted_q && (last_gnt_q == PORT1) && req1 && lock1 &&
                     (lock_cnt_q < LOCK_LIMIT);

  // NOTE: every signal assigned in always_comb gets a default on entry, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (lock0_act) begin
      g0 = 1'b1;
    end else if (lock1_act) begin
      g1 = 1'b1;
    end else if (req0 && req1) begin
      if (FIXED_PRIO != 0 || last_gnt_q == PORT1) g0 = 1'b1;
      else                                        g1 = 1'b1;
    end else begin
      g0 = req0;
      g1 = req1;
    end
  end

  // The grant is gated by reset so the macro sees no access while rsta_n is low.
  assign gnt0 = g0 & rsta_n;
  assign gnt1 = g1 & rsta_n;

  // A locked re-grant extends the burst. Any other cycle (port change, lock
  // dropped, budget exhausted, idle) restarts the count.
  assign lock_cnt_d = (lock0_act || lock1_act) ? lock_cnt_q + CNT_W'(1)
                                               : '0;

  assign mem_ena   = gnt0 | gnt1;
  assign mem_wea   = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addra = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_dina  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      last_gnt_q <= PORT1;
      granted_q  <= 1'b0;
      lock_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_port_q  <= PORT0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (mem_ena) last_gnt_q <= gnt1 ? PORT1 : PORT0;
      granted_q  <= mem_ena;
      lock_cnt_q <= lock_cnt_d;
      // Stage 1: the access has been issued to the macro.
      s1_valid_q <= mem_ena;
      s1_port_q  <= gnt1 ? PORT1 : PORT0;
      // Stage 2: mem_douta is valid now. On a write the macro echoes dina, so
      // writes complete the same way as reads.
      rvalid0_q  <= s1_valid_q && (s1_port_q == PORT0);
      rvalid1_q  <= s1_valid_q && (s1_port_q == PORT1);
      if (s1_valid_q && s1_port_q == PORT0) rdata0_q <= mem_douta;
      if (s1_valid_q && s1_port_q == PORT1) rdata1_q <= mem_douta;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_macro_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_macro_arbiter
//
// Instance u_dut uses the default round-robin configuration and is attached to
// a behavioural single-port macro. Instance u_fp uses fixed priority and has
// only its request inputs driven. Stimulus is a table of per-cycle input and
// expected-output records, followed by hand-written fixed-priority and
// mid-operation reset sequences.
// -----------------------------------------------------------------------------
module tb_mem_macro_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rsta_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_ena, mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina, mem_douta;

  // Fixed-priority instance
  logic          fp_req0, fp_req1;
  logic          fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1;
  logic [DW-1:0] fp_rdata0, fp_rdata1, fp_dina;
  logic          fp_ena, fp_wea;
  logic [AW-1:0] fp_addra;

  mem_macro_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0), .MAX_LOCK(4)) u_dut (
    .clka(clk), .rsta_n(rsta_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  mem_macro_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1), .MAX_LOCK(4)) u_fp (
    .clka(clk), .rsta_n(rsta_n),
    .req0(fp_req0), .req1(fp_req1), .we0(1'b0), .we1(1'b0), .lock0(1'b0), .lock1(1'b0),
    .addr0('0), .addr1('0), .wdata0('0), .wdata1('0),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
    .rdata0(fp_rdata0), .rdata1(fp_rdata1),
    .mem_ena(fp_ena), .mem_wea(fp_wea), .mem_addra(fp_addra),
    .mem_dina(fp_dina), .mem_douta('0)
  );

  // Behavioural single-port macro: registered output, write-first.
  logic [DW-1:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[5] = 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    if (mem_ena) begin
      if (mem_wea) begin
        mem[mem_addra] <= mem_dina;
        mem_douta      <= mem_dina;
      end else begin
        mem_douta      <= mem[mem_addra];
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          r0, r1, w0, w1, l0, l1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rv0, rv1;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic r0, r1, w0, w1, l0, l1,
    input logic [AW-1:0] a0, a1, input logic [DW-1:0] d0, d1,
    input logic g0, g1, wea, input logic [AW-1:0] addr, input logic [DW-1:0] din,
    input logic rv0, rv1, input logic [DW-1:0] rd0, rd1);
    vec_t x;
    x.r0 = r0; x.r1 = r1; x.w0 = w0; x.w1 = w1; x.l0 = l0; x.l1 = l1;
    x.a0 = a0; x.a1 = a1; x.d0 = d0; x.d1 = d1;
    x.g0 = g0; x.g1 = g1; x.wea = wea; x.addr = addr; x.din = din;
    x.rv0 = rv0; x.rv1 = rv1; x.rd0 = rd0; x.rd1 = rd1;
    return x;
  endfunction

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt0"}, gnt0, 0);
    check({tag, ".gnt1"}, gnt1, 0);
    check({tag, ".mem_ena"}, mem_ena, 0);
    check({tag, ".mem_wea"}, mem_wea, 0);
    check({tag, ".mem_addra"}, mem_addra, 0);
    check({tag, ".mem_dina"}, mem_dina, 0);
    check({tag, ".rvalid0"}, rvalid0, 0);
    check({tag, ".rvalid1"}, rvalid1, 0);
    check({tag, ".rdata0"}, rdata0, 0);
    check({tag, ".rdata1"}, rdata1, 0);
    check({tag, ".fp_gnt0"}, fp_gnt0, 0);
  endtask

  localparam logic [DW-1:0] DB = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] WD = 32'h1234_5678;
  localparam logic [DW-1:0] CF = 32'hCAFE_F00D;

  initial begin
    // Round-robin / lock / write-read traffic, one record per cycle.
    //        r0 r1 w0 w1 l0 l1  a0    a1     d0  d1   g0 g1 we addr   din  rv0 rv1 rd0           rd1
    vecs.push_back(v(1,0,0,0,0,0, 10'h5, 0,    0,  0,   1,0,0, 10'h5,  0,   0,0, 0,            0));            // c0 single read
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   0,0, 0,            0));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   1,0, DB,           0));            // c2 rvalid0
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   0,0, DB,           0));            // held
    vecs.push_back(v(0,1,0,0,0,0, 0,10'h20,    0,  0,   0,1,0, 10'h20, 0,   0,0, DB,           0));            // c4
    vecs.push_back(v(1,1,0,0,0,0, 10'h10,10'h11,0, 0,   1,0,0, 10'h10, 0,   0,0, DB,           0));            // c5 conflict
    vecs.push_back(v(1,1,0,0,0,0, 10'h10,10'h11,0, 0,   0,1,0, 10'h11, 0,   0,1, DB,           32'hA500_0020));
    vecs.push_back(v(1,1,0,0,0,0, 10'h10,10'h11,0, 0,   1,0,0, 10'h10, 0,   1,0, 32'hA500_0010,32'hA500_0020));
    vecs.push_back(v(1,1,0,0,0,0, 10'h10,10'h11,0, 0,   0,1,0, 10'h11, 0,   0,1, 32'hA500_0010,32'hA500_0011));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   1,0, 32'hA500_0010,32'hA500_0011));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   0,1, 32'hA500_0010,32'hA500_0011));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   0,0, 32'hA500_0010,32'hA500_0011));
    vecs.push_back(v(0,1,0,0,0,1, 0,10'h30,    0,  0,   0,1,0, 10'h30, 0,   0,0, 32'hA500_0010,32'hA500_0011)); // c12 lock burst start
    vecs.push_back(v(1,1,0,0,0,1, 10'h40,10'h30,0, 0,   0,1,0, 10'h30, 0,   0,0, 32'hA500_0010,32'hA500_0011));
    vecs.push_back(v(1,1,0,0,0,1, 10'h40,10'h30,0, 0,   0,1,0, 10'h30, 0,   0,1, 32'hA500_0010,32'hA500_0030));
    vecs.push_back(v(1,1,0,0,0,1, 10'h40,10'h30,0, 0,   0,1,0, 10'h30, 0,   0,1, 32'hA500_0010,32'hA500_0030));
    vecs.push_back(v(1,1,0,0,0,1, 10'h40,10'h30,0, 0,   1,0,0, 10'h40, 0,   0,1, 32'hA500_0010,32'hA500_0030)); // c16 burst limit
    vecs.push_back(v(1,1,0,0,0,1, 10'h40,10'h30,0, 0,   0,1,0, 10'h30, 0,   0,1, 32'hA500_0010,32'hA500_0030));
    vecs.push_back(v(1,1,0,0,0,0, 10'h40,10'h30,0, 0,   1,0,0, 10'h40, 0,   1,0, 32'hA500_0040,32'hA500_0030));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   0,1, 32'hA500_0040,32'hA500_0030));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   1,0, 32'hA500_0040,32'hA500_0030));
    vecs.push_back(v(0,1,0,1,0,0, 0,10'h3FF,   0,  WD,  0,1,1, 10'h3FF,WD,  0,0, 32'hA500_0040,32'hA500_0030)); // c21 write
    vecs.push_back(v(1,0,0,0,0,0, 10'h3FF,0,   0,  0,   1,0,0, 10'h3FF,0,   0,0, 32'hA500_0040,32'hA500_0030)); // c22 read same addr
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   0,1, 32'hA500_0040,WD));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   1,0, WD,           WD));
    vecs.push_back(v(1,1,1,0,0,0, 10'h1,10'h2, CF, 0,   0,1,0, 10'h2,  0,   0,0, WD,           WD));           // c25
    vecs.push_back(v(1,0,1,0,0,0, 10'h1,0,     CF, 0,   1,0,1, 10'h1,  CF,  0,0, WD,           WD));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   0,1, WD,           32'hA500_0002));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,         0,  0,   0,0,0, 0,      0,   1,0, CF,           32'hA500_0002));

    // Reset state with requests pending.
    rsta_n = 1'b0;
    idle_inputs();
    req0 = 1; req1 = 1; fp_req0 = 1; fp_req1 = 1;
    #3;
    check_all_zero("reset");
    idle_inputs();
    fp_req0 = 0; fp_req1 = 0;
    @(posedge clk); #1;
    rsta_n = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("c%0d", i);
      req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
      lock0 = vecs[i].l0; lock1 = vecs[i].l1; addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
      @(negedge clk);
      check({tag, ".gnt0"},      gnt0,      vecs[i].g0);
      check({tag, ".gnt1"},      gnt1,      vecs[i].g1);
      check({tag, ".mem_ena"},   mem_ena,   vecs[i].g0 | vecs[i].g1);
      check({tag, ".mem_wea"},   mem_wea,   vecs[i].wea);
      check({tag, ".mem_addra"}, mem_addra, vecs[i].addr);
      check({tag, ".mem_dina"},  mem_dina,  vecs[i].din);
      check({tag, ".rvalid0"},   rvalid0,   vecs[i].rv0);
      check({tag, ".rvalid1"},   rvalid1,   vecs[i].rv1);
      check({tag, ".rdata0"},    rdata0,    vecs[i].rd0);
      check({tag, ".rdata1"},    rdata1,    vecs[i].rd1);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Fixed priority: both ports request for three cycles, port 0 always wins.
    fp_req0 = 1; fp_req1 = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("fp%0d.gnt0", k), fp_gnt0, 1);
      check($sformatf("fp%0d.gnt1", k), fp_gnt1, 0);
      @(posedge clk); #1;
    end
    fp_req0 = 0; fp_req1 = 0;

    // Reset one cycle after a grant: the access is dropped, outputs clear.
    req0 = 1; addr0 = 10'h5;
    @(negedge clk);
    check("rst_mid.gnt0", gnt0, 1);
    @(posedge clk); #1;
    rsta_n = 1'b0;             // req0 is still high
    #1;
    check_all_zero("rst_mid.async");
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid.t2_rvalid0", rvalid0, 0);
    check("rst_mid.t2_gnt0", gnt0, 0);
    @(posedge clk); #1;
    rsta_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst_post%0d.rvalid0", k), rvalid0, 0);
      @(posedge clk); #1;
    end

    // First read after reset: normal latency, data from the earlier write.
    req0 = 1; addr0 = 10'h3FF;
    @(negedge clk);
    check("post_rd.gnt0", gnt0, 1);
    check("post_rd.mem_addra", mem_addra, 10'h3FF);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("post_rd.t1_rvalid0", rvalid0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rd.t2_rvalid0", rvalid0, 1);
    check("post_rd.t2_rdata0", rdata0, WD);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rd.t3_rvalid0", rvalid0, 0);
    check("post_rd.t3_rdata0", rdata0, WD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_macro_arbiter.md
# mem_macro_arbiter

Two-requester arbiter and sequencer for one single-port cache/memory macro. It sits between the instruction-fetch side (port 0) and the load/store side (port 1) and the macro's clka/ena/wea/addra/dina/douta interface. Each cycle it grants at most one request and drives the macro. It returns read or write completion data to the winning port at a fixed latency. Arbitration is round-robin or fixed-priority, with bounded lock bursts.

## Interface
- ADDR_WIDTH, 10, macro word-address width; passed straight to mem_addra.
- DATA_WIDTH, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins a conflict.
- MAX_LOCK, 4, maximum consecutive grants one port may hold via lock (≥1).

Ports:
- clka  in  1  clock; all logic is on the rising edge.
- rsta_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  request valid, held until gnt.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  request to keep the grant for the next beat.
- addr0 / addr1  in  ADDR_WIDTH  word address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  combinational grant; the request is accepted this cycle.
- rvalid0 / rvalid1  out  1  registered completion pulse for the port.
- rdata0 / rdata1  out  DATA_WIDTH  registered completion data, held until the port's next rvalid.
- mem_ena  out  1  macro enable (equals gnt0|gnt1).
- mem_wea  out  1  macro write enable.
- mem_addra  out  ADDR_WIDTH  macro address.
- mem_dina  out  DATA_WIDTH  macro write data.
- mem_douta  in  DATA_WIDTH  macro output; registered by the macro, valid the cycle after mem_ena.

## Operation
- Grant is combinational from req0, req1, last_gnt and the lock state. gnt0 and gnt1 are never both 1.
- mem_ena, mem_wea, mem_addra and mem_dina are muxed from the granted port. With no grant, mem_ena=0, mem_wea=0, and addr/din are 0.
- Single request: that port is granted the same cycle.
- Conflict, FIXED_PRIO=0: grant the port not in last_gnt. last_gnt updates on every grant and resets to 1, so port 0 wins the first conflict.
- Conflict, FIXED_PRIO=1: port 0 wins.
- Lock: the port granted in cycle T keeps priority in T+1 if it asserts lockN and reqN in T+1 and lock_cnt < MAX_LOCK-1.
  - lock_cnt increments on each locked re-grant.
  - lock_cnt clears to 0 when the grant changes port, lock drops, or a cycle has no grant.
  - When lock_cnt reaches MAX_LOCK-1, the next conflict falls back to normal arbitration.
- Completion pipeline: 2-stage shift of {valid, port}.
  - Stage 1 is loaded at grant.
  - Stage 2 asserts rvalidN and captures rdataN ← mem_douta.
  - Writes also complete: the macro returns dina on a write, so rdataN equals the written data.
- Back-to-back grants every cycle are supported. Completions stay in grant order, one per cycle.
- Same-address read after write on consecutive cycles returns the new data (macro write is at the same edge as the next read).

## Timing
- Grant at cycle T (edge at end of T drives the macro). mem_douta is valid in T+1. rvalidN is high for exactly one cycle in T+2, with rdataN valid from T+2 onward.
- Throughput is 1 access per cycle total, shared by both ports.
- Reset (rsta_n=0, any time, asynchronously):
  - gnt0 = gnt1 = 0 and all mem_* outputs = 0 while reset is asserted.
  - rvalid0 = rvalid1 = 0; rdata0 = rdata1 = 0.
  - Pipeline valids clear; in-flight accesses are dropped with no rvalid.
  - last_gnt = 1; lock_cnt = 0.
- First cycle after reset release: requests are arbitrated normally.
- A request deasserted before grant is simply not served. Requesters must not drop req before gnt; this is a protocol requirement, not checked.

## Test plan
- Reset, then a single read: req0=1, we0=0, addr0=0x005 with mem[5]=0xDEADBEEF. Expect gnt0 in T, mem_ena=1 and mem_addra=0x005 in T, rvalid0 in T+2, rdata0=0xDEADBEEF held afterwards.
- Conflict in round-robin: req0 and req1 held for 4 cycles. Expect grants 0,1,0,1, rvalid order 0,1,0,1 each two cycles after its grant, and never both gnt high.
- Lock burst with MAX_LOCK=4: port 1 holds lock1=1 and req1, port 0 requesting continuously. Expect 4 consecutive gnt1, then gnt0, and lock_cnt back to 0.
- FIXED_PRIO=1 with both requesting for 3 cycles: expect gnt0 ×3 and gnt1=0 throughout.
- Write then read the same address: port 1 writes 0x12345678 to 0x3FF at T, port 0 reads 0x3FF at T+1. Expect rdata1=0x12345678 at T+2 and rdata0=0x12345678 at T+3.
- Reset mid-operation: assert rsta_n=0 one cycle after a grant. Expect no rvalid for that access and all outputs 0 during reset; the first post-reset read returns correct data with normal latency.
